// File: rtl/tone_sweep_gen.sv
// tone_sweep_gen
//    Square-wave tone generator with a swept half-period divider. A free
//    running sweep counter supplies a ramp. The ramp is shaped by mode, then
//    shifted and added to base_div to give the reload value of a half-period
//    down-counter. The divider is sampled only when the counter reloads.
//
// Ports
//    clk          single clock for all state
//    rst_n        asynchronous active-low reset
//    enable       1 = run, 0 = mute (speaker/period_tick forced low, sweep held)
//    mode[1:0]    00 fixed, 01 sawtooth, 10 triangle, 11 two-tone
//    base_div     base half-period minus one
//    speaker      square-wave output
//    period_tick  one-cycle pulse on each 0->1 edge of speaker
//
// Configuration
//    TONE_SWEEP_GATE_EN  when defined, speaker and period_tick are gated off
//                        while sweep[SWEEP_W-4] is 1 (beep-beep cadence).
//                        The internal counter and toggle state keep running.

module tone_sweep_gen #(
   parameter int DIV_W      = 15,
   parameter int SWEEP_W    = 24,
   parameter int RAMP_W     = 7,
   parameter int RAMP_SHIFT = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] base_div,
   output logic             speaker,
   output logic             period_tick
);

   // Wide enough for the unsaturated sum of both operands.
   localparam int SUM_W = DIV_W + RAMP_W + RAMP_SHIFT + 1;

   logic [SWEEP_W-1:0] sweep_q, sweep_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic               spk_q, spk_d;
   logic               tick_q, tick_d;

   logic [RAMP_W-1:0]  ramp_raw;
   logic               ramp_msb;
   logic [RAMP_W-1:0]  ramp;
   logic [SUM_W-1:0]   div_sum;
   logic [DIV_W-1:0]   divider;

   assign ramp_raw = sweep_q[SWEEP_W-2 -: RAMP_W];
   assign ramp_msb = sweep_q[SWEEP_W-1];

   always_comb begin
      ramp = '0;
      case (mode)
         2'b00:   ramp = '0;
         2'b01:   ramp = ramp_raw;
         2'b10:   ramp = ramp_msb ? ramp_raw : ~ramp_raw;
         default: ramp = ramp_msb ? '1 : '0;
      endcase
   end

   always_comb begin
      div_sum = SUM_W'(base_div) + (SUM_W'(ramp) << RAMP_SHIFT);
      if (div_sum > SUM_W'({DIV_W{1'b1}})) begin
         divider = '1;
      end else begin
         divider = div_sum[DIV_W-1:0];
      end
   end

   // While muted the counter parks at 0, so the first enabled edge always
   // reloads and raises speaker, starting a fresh period.
   always_comb begin
      sweep_d = sweep_q;
      cnt_d   = cnt_q;
      spk_d   = spk_q;
      tick_d  = 1'b0;
      if (!enable) begin
         cnt_d = '0;
         spk_d = 1'b0;
      end else begin
         sweep_d = sweep_q + SWEEP_W'(1);
         if (cnt_q == '0) begin
            cnt_d  = divider;
            spk_d  = ~spk_q;
            tick_d = ~spk_q;
         end else begin
            cnt_d = cnt_q - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sweep_q <= '0;
         cnt_q   <= '0;
         spk_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sweep_q <= sweep_d;
         cnt_q   <= cnt_d;
         spk_q   <= spk_d;
         tick_q  <= tick_d;
      end
   end

`ifdef TONE_SWEEP_GATE_EN
   assign speaker     = spk_q  & ~sweep_q[SWEEP_W-4];
   assign period_tick = tick_q & ~sweep_q[SWEEP_W-4];
`else
   assign speaker     = spk_q;
   assign period_tick = tick_q;
`endif

endmodule
